// File: rtl/trisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trisc_pkg
// Description : Shared TRISC opcodes, default widths, decode struct and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package trisc_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_OPC_W  = 4;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_CNT_W  = 16;
    localparam int MAX_W      = 32;

    localparam logic [DEF_OPC_W-1:0] OPC_LDA = 4'h0;
    localparam logic [DEF_OPC_W-1:0] OPC_STA = 4'h1;
    localparam logic [DEF_OPC_W-1:0] OPC_ADD = 4'h2;
    localparam logic [DEF_OPC_W-1:0] OPC_SUB = 4'h3;
    localparam logic [DEF_OPC_W-1:0] OPC_XOR = 4'h4;
    localparam logic [DEF_OPC_W-1:0] OPC_INC = 4'h5;
    localparam logic [DEF_OPC_W-1:0] OPC_CLR = 4'h6;
    localparam logic [DEF_OPC_W-1:0] OPC_JMP = 4'h7;
    localparam logic [DEF_OPC_W-1:0] OPC_JPZ = 4'h8;
    localparam logic [DEF_OPC_W-1:0] OPC_JPN = 4'h9;
    localparam logic [DEF_OPC_W-1:0] OPC_HLT = 4'hF;

    typedef struct packed {
        logic lda;
        logic sta;
        logic add;
        logic sub;
        logic xor_op;
        logic inc;
        logic clr;
        logic jmp;
        logic jpz;
        logic jpn;
        logic hlt;
        logic nop;
    } dec_lines_t;

    // Word is passed zero-extended so one helper serves any DATA_W up to MAX_W.
    function automatic logic [DEF_OPC_W-1:0] opc_field(input logic [MAX_W-1:0] word,
                                                      input int data_w);
        return DEF_OPC_W'(word >> (data_w - DEF_OPC_W));
    endfunction

    function automatic logic [MAX_W-1:0] addr_field(input logic [MAX_W-1:0] word,
                                                   input int addr_w);
        return word & ((MAX_W'(1) << addr_w) - MAX_W'(1));
    endfunction

    function automatic logic is_illegal(input logic [DEF_OPC_W-1:0] opc);
        return (opc inside {[4'hA:4'hE]});
    endfunction

    function automatic dec_lines_t decode_opc(input logic [DEF_OPC_W-1:0] opc,
                                              input logic z,
                                              input logic n);
        dec_lines_t d;
        d = '0;
        case (opc)
            OPC_LDA: d.lda    = 1'b1;
            OPC_STA: d.sta    = 1'b1;
            OPC_ADD: d.add    = 1'b1;
            OPC_SUB: d.sub    = 1'b1;
            OPC_XOR: d.xor_op = 1'b1;
            OPC_INC: d.inc    = 1'b1;
            OPC_CLR: d.clr    = 1'b1;
            OPC_JMP: d.jmp    = 1'b1;
            OPC_JPZ: begin
                d.jpz = z;
                d.jmp = z;
                d.nop = ~z;
            end
            OPC_JPN: begin
                d.jpn = n;
                d.jmp = n;
                d.nop = ~n;
            end
            OPC_HLT: d.hlt    = 1'b1;
            default: d.nop    = 1'b1;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : ir_decode_if
// Description : Controller <-> instruction decoder bus with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface ir_decode_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic              ir_load;
    logic [DATA_W-1:0] mem_data;
    logic              acc_write;
    logic [DATA_W-1:0] acc_value;
    logic              resume;

    logic LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT;
    logic              nop;
    logic [ADDR_W-1:0] addr;
    logic              flag_z;
    logic              flag_n;
    logic              halted;
    logic              illegal;
    logic [CNT_W-1:0]  retired;

    modport master (
        output ir_load, mem_data, acc_write, acc_value, resume,
        input  LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT,
        input  nop, addr, flag_z, flag_n, halted, illegal, retired
    );

    modport slave (
        input  ir_load, mem_data, acc_write, acc_value, resume,
        output LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT,
        output nop, addr, flag_z, flag_n, halted, illegal, retired
    );
endinterface
`default_nettype wire

// File: rtl/trisc_flags.sv
`default_nettype none
// ============================================================================
// Module      : trisc_flags
// Description : Z/N status flag register updated on accumulator writes.
// Revision    : 1.0 - initial release
// ============================================================================
module trisc_flags
    import trisc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              acc_write,
    input  wire logic [DATA_W-1:0] acc_value,
    output logic                   flag_z,
    output logic                   flag_n
);

    logic r_z;
    logic r_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_z <= 1'b0;
            r_n <= 1'b0;
        end else if (acc_write) begin
            r_z <= (acc_value == '0);
            r_n <= acc_value[DATA_W-1];
        end
    end

    assign flag_z = r_z;
    assign flag_n = r_n;

endmodule
`default_nettype wire

// File: rtl/ir_decode.sv
`default_nettype none
// ============================================================================
// Module      : ir_decode
// Description : TRISC instruction register, one-hot decoder, halt latch and
//               retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_decode
    import trisc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OPC_W  = DEF_OPC_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input wire logic   clock,
    input wire logic   reset,
    ir_decode_if.slave bus
);

    logic [DATA_W-1:0]    r_ir;
    dec_lines_t           r_dec;
    logic                 r_halted;
    logic                 r_illegal;
    logic [CNT_W-1:0]     r_retired;

    logic                 w_flag_z;
    logic                 w_flag_n;
    logic [DEF_OPC_W-1:0] w_opc;
    dec_lines_t           w_dec;
    logic                 w_accept;

    trisc_flags #(
        .DATA_W (DATA_W)
    ) u_flags (
        .clock     (clock),
        .reset     (reset),
        .acc_write (bus.acc_write),
        .acc_value (bus.acc_value),
        .flag_z    (w_flag_z),
        .flag_n    (w_flag_n)
    );

    // Jumps resolve against the flags as they stood before this edge.
    assign w_opc    = opc_field(MAX_W'(bus.mem_data), DATA_W);
    assign w_dec    = decode_opc(w_opc, w_flag_z, w_flag_n);
    assign w_accept = bus.ir_load && !r_halted;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ir      <= '0;
            r_dec     <= '0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else if (r_halted && bus.resume) begin
            r_halted <= 1'b0;
            r_dec    <= '0;
        end else if (w_accept) begin
            r_ir  <= bus.mem_data;
            r_dec <= w_dec;
            if (w_opc == OPC_HLT) begin
                r_halted <= 1'b1;
            end
            if (is_illegal(w_opc)) begin
                r_illegal <= 1'b1;
            end
            if (r_retired != {CNT_W{1'b1}}) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign bus.LDA     = r_dec.lda;
    assign bus.STA     = r_dec.sta;
    assign bus.ADD     = r_dec.add;
    assign bus.SUB     = r_dec.sub;
    assign bus.XOR     = r_dec.xor_op;
    assign bus.INC     = r_dec.inc;
    assign bus.CLR     = r_dec.clr;
    assign bus.JMP     = r_dec.jmp;
    assign bus.JPZ     = r_dec.jpz;
    assign bus.JPN     = r_dec.jpn;
    assign bus.HLT     = r_dec.hlt;
    assign bus.nop     = r_dec.nop;
    assign bus.addr    = ADDR_W'(addr_field(MAX_W'(r_ir), ADDR_W));
    assign bus.flag_z  = w_flag_z;
    assign bus.flag_n  = w_flag_n;
    assign bus.halted  = r_halted;
    assign bus.illegal = r_illegal;
    assign bus.retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_ir_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_decode
// Description : Directed vector bench for ir_decode (16-bit and 4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_decode;

    localparam logic [11:0] L_LDA = 12'h800;
    localparam logic [11:0] L_STA = 12'h400;
    localparam logic [11:0] L_ADD = 12'h200;
    localparam logic [11:0] L_SUB = 12'h100;
    localparam logic [11:0] L_XOR = 12'h080;
    localparam logic [11:0] L_INC = 12'h040;
    localparam logic [11:0] L_CLR = 12'h020;
    localparam logic [11:0] L_JMP = 12'h010;
    localparam logic [11:0] L_JPZ = 12'h008;
    localparam logic [11:0] L_JPN = 12'h004;
    localparam logic [11:0] L_HLT = 12'h002;
    localparam logic [11:0] L_NOP = 12'h001;
    localparam int          NVEC  = 23;

    typedef struct {
        logic        ld;
        logic [7:0]  mem;
        logic        aw;
        logic [7:0]  av;
        logic        res;
        logic [11:0] lines;
        logic [3:0]  addr;
        logic        z;
        logic        n;
        logic        h;
        logic        ill;
        logic [15:0] ret;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ir_decode_if #(.DATA_W(8), .ADDR_W(4), .CNT_W(16)) bus ();
    ir_decode_if #(.DATA_W(8), .ADDR_W(4), .CNT_W(4))  bus4 ();

    assign bus4.ir_load   = bus.ir_load;
    assign bus4.mem_data  = bus.mem_data;
    assign bus4.acc_write = bus.acc_write;
    assign bus4.acc_value = bus.acc_value;
    assign bus4.resume    = bus.resume;

    ir_decode #(.DATA_W(8), .OPC_W(4), .ADDR_W(4), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    ir_decode #(.DATA_W(8), .OPC_W(4), .ADDR_W(4), .CNT_W(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    always #5 clock = ~clock;

    logic [11:0] lines;
    assign lines = {bus.LDA, bus.STA, bus.ADD, bus.SUB, bus.XOR, bus.INC,
                    bus.CLR, bus.JMP, bus.JPZ, bus.JPN, bus.HLT, bus.nop};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [11:0] e_lines, input logic [3:0] e_addr,
                             input logic e_z, input logic e_n, input logic e_h, input logic e_ill,
                             input logic [15:0] e_ret);
        logic [15:0] e_ret4;
        e_ret4 = (e_ret > 16'd15) ? 16'd15 : e_ret;
        check({tag, " lines"},    32'(lines),        32'(e_lines));
        check({tag, " addr"},     32'(bus.addr),     32'(e_addr));
        check({tag, " flag_z"},   32'(bus.flag_z),   32'(e_z));
        check({tag, " flag_n"},   32'(bus.flag_n),   32'(e_n));
        check({tag, " halted"},   32'(bus.halted),   32'(e_h));
        check({tag, " illegal"},  32'(bus.illegal),  32'(e_ill));
        check({tag, " retired"},  32'(bus.retired),  32'(e_ret));
        check({tag, " retired4"}, 32'(bus4.retired), 32'(e_ret4));
    endtask

    vec_t vecs [NVEC];

    initial begin
        //          ld  mem    aw  av     res lines          addr  z  n  h  ill ret
        vecs[0]  = '{1, 8'h3A, 0, 8'h00, 0, L_SUB,         4'hA, 0, 0, 0, 0, 16'd1};
        vecs[1]  = '{0, 8'h00, 1, 8'h00, 0, L_SUB,         4'hA, 1, 0, 0, 0, 16'd1};
        vecs[2]  = '{1, 8'h85, 0, 8'h00, 0, L_JPZ | L_JMP, 4'h5, 1, 0, 0, 0, 16'd2};
        vecs[3]  = '{0, 8'h00, 1, 8'h40, 0, L_JPZ | L_JMP, 4'h5, 0, 0, 0, 0, 16'd2};
        vecs[4]  = '{1, 8'h92, 0, 8'h00, 0, L_NOP,         4'h2, 0, 0, 0, 0, 16'd3};
        vecs[5]  = '{1, 8'h99, 1, 8'h80, 0, L_NOP,         4'h9, 0, 1, 0, 0, 16'd4};
        vecs[6]  = '{1, 8'h99, 0, 8'h00, 0, L_JPN | L_JMP, 4'h9, 0, 1, 0, 0, 16'd5};
        vecs[7]  = '{1, 8'h88, 1, 8'h00, 0, L_NOP,         4'h8, 1, 0, 0, 0, 16'd6};
        vecs[8]  = '{1, 8'hF0, 0, 8'h00, 0, L_HLT,         4'h0, 1, 0, 1, 0, 16'd7};
        vecs[9]  = '{1, 8'h10, 0, 8'h00, 0, L_HLT,         4'h0, 1, 0, 1, 0, 16'd7};
        vecs[10] = '{0, 8'h00, 1, 8'hFF, 0, L_HLT,         4'h0, 0, 1, 1, 0, 16'd7};
        vecs[11] = '{1, 8'h10, 0, 8'h00, 1, 12'h000,       4'h0, 0, 1, 0, 0, 16'd7};
        vecs[12] = '{0, 8'h00, 0, 8'h00, 1, 12'h000,       4'h0, 0, 1, 0, 0, 16'd7};
        vecs[13] = '{1, 8'hC3, 0, 8'h00, 0, L_NOP,         4'h3, 0, 1, 0, 1, 16'd8};
        vecs[14] = '{1, 8'h50, 0, 8'h00, 0, L_INC,         4'h0, 0, 1, 0, 1, 16'd9};
        vecs[15] = '{1, 8'h00, 0, 8'h00, 0, L_LDA,         4'h0, 0, 1, 0, 1, 16'd10};
        vecs[16] = '{1, 8'h1F, 0, 8'h00, 0, L_STA,         4'hF, 0, 1, 0, 1, 16'd11};
        vecs[17] = '{1, 8'h2E, 0, 8'h00, 0, L_ADD,         4'hE, 0, 1, 0, 1, 16'd12};
        vecs[18] = '{1, 8'h41, 0, 8'h00, 0, L_XOR,         4'h1, 0, 1, 0, 1, 16'd13};
        vecs[19] = '{1, 8'h62, 0, 8'h00, 0, L_CLR,         4'h2, 0, 1, 0, 1, 16'd14};
        vecs[20] = '{1, 8'h7D, 0, 8'h00, 0, L_JMP,         4'hD, 0, 1, 0, 1, 16'd15};
        vecs[21] = '{1, 8'h00, 0, 8'h00, 0, L_LDA,         4'h0, 0, 1, 0, 1, 16'd16};
        vecs[22] = '{1, 8'h00, 0, 8'h00, 0, L_LDA,         4'h0, 0, 1, 0, 1, 16'd17};

        bus.ir_load   = 1'b0;
        bus.mem_data  = 8'h00;
        bus.acc_write = 1'b0;
        bus.acc_value = 8'h00;
        bus.resume    = 1'b0;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_all("reset", 12'h000, 4'h0, 0, 0, 0, 0, 16'd0);

        // Idle cycle: IR=0 must not be decoded as LDA until a real load.
        @(negedge clock);
        check_all("idle", 12'h000, 4'h0, 0, 0, 0, 0, 16'd0);

        for (int i = 0; i < NVEC; i++) begin
            bus.ir_load   = vecs[i].ld;
            bus.mem_data  = vecs[i].mem;
            bus.acc_write = vecs[i].aw;
            bus.acc_value = vecs[i].av;
            bus.resume    = vecs[i].res;
            @(negedge clock);
            check_all($sformatf("vec%0d", i), vecs[i].lines, vecs[i].addr, vecs[i].z,
                      vecs[i].n, vecs[i].h, vecs[i].ill, vecs[i].ret);
        end

        bus.ir_load   = 1'b0;
        bus.acc_write = 1'b0;
        bus.resume    = 1'b0;

        // Asynchronous reset between edges must clear state without a clock.
        #2;
        reset = 1'b1;
        #1;
        check_all("async_reset", 12'h000, 4'h0, 0, 0, 0, 0, 16'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_all("post_reset", 12'h000, 4'h0, 0, 0, 0, 0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
